commit_arbiter: RTL and testbench
=================================

Name: commit_arbiter

Overview:
Shares the single register-file write port and the single scoreboard release port (occupancy address/write) among N execution units (ALU, MUL, DIV, LSU). Each unit presents a completed result with a valid/ready handshake. Round-robin arbitration grants one unit per cycle. The granted result is driven through a registered commit stage to the register file and to the scoreboard release interface.

Parameters:
N_UNITS, 4, number of result producers (2..8)
XLEN, core_config_pkg::XLEN (32), result data width
REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), destination register index width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
unit_valid  in  N_UNITS  unit i holds a completed result
unit_ready  out  N_UNITS  one-hot grant; transfer when unit_valid[i] && unit_ready[i]
unit_rd  in  N_UNITS*REG_ADDR_W  packed destination register per unit (unit i at [i*REG_ADDR_W +: REG_ADDR_W])
unit_data  in  N_UNITS*XLEN  packed result data per unit
rf_we  out  1  register-file write enable
rf_addr  out  REG_ADDR_W  register-file write index
rf_data  out  XLEN  register-file write data
sb_write  out  1  scoreboard release strobe (to occupancy write)
sb_address  out  REG_ADDR_W  released register (to occupancy address)
commit_unit  out  $clog2(N_UNITS)  index of the unit committed this cycle (debug/trace)

Behaviour:
- Reset values: rf_we=0, sb_write=0, rf_addr=0, rf_data=0, sb_address=0, commit_unit=0, rr_ptr=0.
- unit_ready is combinational from unit_valid and rr_ptr. Only the first valid unit at or after rr_ptr (modulo N_UNITS) sees ready=1. unit_ready is all-zero when no unit is valid.
- A unit keeps unit_valid, unit_rd and unit_data stable until its transfer. Deasserting valid before transfer is illegal; an SVA flags it.
- On transfer of unit g in cycle t, these outputs are registered:
  - rf_we, rf_addr=unit_rd[g], rf_data=unit_data[g] and commit_unit=g are visible in cycle t+1, for one cycle.
  - sb_write and sb_address carry the same index in the same cycle t+1.
  - Latency is 1 cycle. Throughput is 1 commit per cycle.
- rr_ptr update on transfer: rr_ptr <= (g+1) mod N_UNITS. rr_ptr holds when there is no transfer. A continuously valid unit waits at most N_UNITS-1 cycles.
- rd == 0: the transfer completes normally and rr_ptr advances, but rf_we=0 and sb_write=0 for that commit. x0 is never written or released.
- No transfer in a cycle: rf_we=0 and sb_write=0 next cycle; rf_addr and rf_data hold their previous values.
- Two units targeting the same rd: not prevented by this block (the scoreboard forbids it at issue). If it occurs, both commit in round-robin order on consecutive cycles and the last write wins.
- Scoreboard write in the same cycle as a scoreboard lock: handled inside the scoreboard. This block only guarantees sb_write is a single-cycle pulse per commit.
- Reset asserted mid-operation: all outputs and rr_ptr clear asynchronously. A result registered but not yet committed is discarded. Units must also be reset.

Optional Feature:
COMMIT_ARB_STATS_EN
- Defined: adds outputs stat_commits (N_UNITS*32, per-unit commit counters) and stat_conflicts (32, counts cycles with more than one unit valid). All counters saturate at 2^32-1 and clear on reset.
- Undefined: ports and counters are absent. Function and timing are otherwise identical.

Decomposition:
- core_config_pkg gains N_EXEC_UNITS and the unit-index enum (UNIT_ALU=0, UNIT_MUL, UNIT_DIV, UNIT_LSU), plus the commit_t struct {valid, rd, data, unit}.
- One sub-module: rr_arbiter. It is parameterised by N, takes req vector and pointer, and returns a one-hot grant plus the encoded index. It is reusable for the issue and LSU port arbiters.

Test Plan:
- Single request: unit 2 valid with rd=5, data=0xDEADBEEF, rr_ptr=0 -> unit_ready=4'b0100 same cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, sb_write=1, sb_address=5, commit_unit=2; rr_ptr=3.
- Fairness: all 4 units continuously valid with distinct rd 1..4 -> commits in order 0,1,2,3,0,... one per cycle; no unit waits more than 3 cycles.
- x0 write: unit 1 valid with rd=0, data=0x1234 -> unit_ready[1]=1; next cycle rf_we=0, sb_write=0; rr_ptr=2.
- Back-pressure: units 0 and 3 valid, rr_ptr=1 -> unit 3 granted first, unit 0 next cycle; unit 0 data held stable throughout; commits to rd of 3 then 0.
- Reset mid-stream: assert rst_n=0 in the cycle after a transfer -> rf_we and sb_write drop immediately; after release all outputs are 0 and rr_ptr=0.
- COMMIT_ARB_STATS_EN: 10 cycles with units 0 and 1 always valid -> stat_commits[0]=5, stat_commits[1]=5, stat_conflicts=10.

Source files
------------

// File: rtl/commit_arbiter_pkg.sv
// Shared commit-path types: unit indices, commit record and saturating counter helper.
package commit_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int N_EXEC_UNITS = 4;
  localparam int UNIT_IDX_W   = $clog2(N_EXEC_UNITS);

  typedef enum logic [UNIT_IDX_W-1:0] {
    UNIT_ALU = 0,
    UNIT_MUL,
    UNIT_DIV,
    UNIT_LSU
  } unit_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [UNIT_IDX_W-1:0] unit;
  } commit_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/commit_arbiter_if.sv
// Result-unit handshake plus register-file / scoreboard commit bus.
// Stats outputs exist only when COMMIT_ARB_STATS_EN is defined.
interface commit_arbiter_if #(
  parameter int N_UNITS    = 4,
  parameter int XLEN       = commit_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = commit_arbiter_pkg::REG_ADDR_W
);
  localparam int IDX_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0]            unit_valid;
  logic [N_UNITS-1:0]            unit_ready;
  logic [N_UNITS*REG_ADDR_W-1:0] unit_rd;
  logic [N_UNITS*XLEN-1:0]       unit_data;
  logic                          rf_we;
  logic [REG_ADDR_W-1:0]         rf_addr;
  logic [XLEN-1:0]               rf_data;
  logic                          sb_write;
  logic [REG_ADDR_W-1:0]         sb_address;
  logic [IDX_W-1:0]              commit_unit;
`ifdef COMMIT_ARB_STATS_EN
  logic [N_UNITS*32-1:0]         stat_commits;
  logic [31:0]                   stat_conflicts;
`endif

  // Execution units / environment side
  modport master (
    output unit_valid, unit_rd, unit_data,
    input  unit_ready, rf_we, rf_addr, rf_data, sb_write, sb_address, commit_unit
`ifdef COMMIT_ARB_STATS_EN
    , stat_commits, stat_conflicts
`endif
  );

  // Arbiter side
  modport slave (
    input  unit_valid, unit_rd, unit_data,
    output unit_ready, rf_we, rf_addr, rf_data, sb_write, sb_address, commit_unit
`ifdef COMMIT_ARB_STATS_EN
    , stat_commits, stat_conflicts
`endif
  );

endinterface

// File: rtl/commit_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: first requester at or after ptr_i wins (one-hot + index).
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int   j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/commit_arbiter.sv
// Round-robin commit of unit results into the single RF write / scoreboard release port.
// Optional per-unit commit and conflict counters: define COMMIT_ARB_STATS_EN.
module commit_arbiter #(
  parameter int N_UNITS    = 4,
  parameter int XLEN       = commit_arbiter_pkg::XLEN,
  parameter int REG_ADDR_W = commit_arbiter_pkg::REG_ADDR_W
) (
  input logic             clk,
  input logic             rst_n,
  commit_arbiter_if.slave bus
);
  import commit_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_UNITS);

  logic [N_UNITS-1:0]    gnt;
  logic [IDX_W-1:0]      gidx;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] g_rd;
  logic [XLEN-1:0]       g_data;
  logic                  we_d;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  rf_we_q, sb_write_q;
  logic [REG_ADDR_W-1:0] rf_addr_q, sb_address_q;
  logic [XLEN-1:0]       rf_data_q;
  logic [IDX_W-1:0]      commit_unit_q;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .req_i (bus.unit_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign bus.unit_ready = gnt;
  assign xfer           = |gnt;

  // Grant is one-hot, so an AND-OR mux selects the winning result
  always_comb begin
    g_rd   = '0;
    g_data = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (gnt[i]) begin
        g_rd   = g_rd   | bus.unit_rd[i*REG_ADDR_W +: REG_ADDR_W];
        g_data = g_data | bus.unit_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 commits still consume the grant but never write or release
  assign we_d = xfer && (g_rd != '0);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (gidx == IDX_W'(N_UNITS - 1)) ? '0 : gidx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      rf_we_q       <= 1'b0;
      sb_write_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
      sb_address_q  <= '0;
      commit_unit_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= we_d;
      sb_write_q <= we_d;
      if (xfer) begin
        rf_addr_q     <= g_rd;
        rf_data_q     <= g_data;
        sb_address_q  <= g_rd;
        commit_unit_q <= gidx;
      end
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_data     = rf_data_q;
  assign bus.sb_write    = sb_write_q;
  assign bus.sb_address  = sb_address_q;
  assign bus.commit_unit = commit_unit_q;

`ifdef COMMIT_ARB_STATS_EN
  logic [N_UNITS*32-1:0] stat_commits_q;
  logic [31:0]           stat_conflicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commits_q   <= '0;
      stat_conflicts_q <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (gnt[i]) stat_commits_q[i*32 +: 32] <= sat_inc32(stat_commits_q[i*32 +: 32]);
      end
      if ($countones(bus.unit_valid) > 1) stat_conflicts_q <= sat_inc32(stat_conflicts_q);
    end
  end

  assign bus.stat_commits   = stat_commits_q;
  assign bus.stat_conflicts = stat_conflicts_q;
`endif

`ifndef SYNTHESIS
  // A waiting unit must hold valid, rd and data until it is granted
  for (genvar i = 0; i < N_UNITS; i++) begin : g_hold_chk
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.unit_valid[i] && !bus.unit_ready[i]) |=>
        (bus.unit_valid[i] &&
         $stable(bus.unit_rd[i*REG_ADDR_W +: REG_ADDR_W]) &&
         $stable(bus.unit_data[i*XLEN +: XLEN])));
  end
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Scoreboard bench for commit_arbiter: directed vectors, hand-ordered expected commits.
module tb_commit_arbiter;

  localparam int N  = 4;
  localparam int XW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [XW-1:0] data;
  } item_t;

  typedef struct packed {
    logic [1:0]    unit;
    logic          we;
    logic [AW-1:0] rd;
    logic [XW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  commit_arbiter_if #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(AW)) bus ();

  commit_arbiter #(.N_UNITS(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t uq[N][$];
  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic unit_push(input int u, input logic [AW-1:0] rd, input logic [XW-1:0] data);
    item_t it;
    it.rd   = rd;
    it.data = data;
    uq[u].push_back(it);
  endtask

  task automatic exp_push(input int u, input logic we, input logic [AW-1:0] rd, input logic [XW-1:0] data);
    exp_t e;
    e.unit = 2'(u);
    e.we   = we;
    e.rd   = rd;
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic advance(input int i);
    item_t it;
    if (uq[i].size() > 0) begin
      it = uq[i].pop_front();
      bus.unit_valid[i]         = 1'b1;
      bus.unit_rd[i*AW +: AW]   = it.rd;
      bus.unit_data[i*XW +: XW] = it.data;
    end else begin
      bus.unit_valid[i] = 1'b0;
    end
  endtask

  task automatic load_idle();
    for (int i = 0; i < N; i++) if (!bus.unit_valid[i]) advance(i);
  endtask

  // One clock: sample handshakes mid-cycle, then replace consumed results
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = bus.unit_valid & bus.unit_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) advance(i);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (bus.unit_valid != '0 && c < maxc) begin
      step();
      c++;
    end
    if (bus.unit_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: valid=0x%0h still pending after %0d cycles", bus.unit_valid, maxc);
      bus.unit_valid = '0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"},       64'(bus.rf_we),       64'd0);
    chk({tag, "_sb_write"},    64'(bus.sb_write),    64'd0);
    chk({tag, "_rf_addr"},     64'(bus.rf_addr),     64'd0);
    chk({tag, "_rf_data"},     64'(bus.rf_data),     64'd0);
    chk({tag, "_sb_address"},  64'(bus.sb_address),  64'd0);
    chk({tag, "_commit_unit"}, 64'(bus.commit_unit), 64'd0);
  endtask

  // Monitor: pops on each observed handshake, checks the commit one cycle later
  initial begin
    exp_t         pw;
    logic         pend;
    logic [N-1:0] fire;
    pend = 1'b0;
    pw   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("commit_rf_we",       64'(bus.rf_we),       64'(pw.we));
          chk("commit_sb_write",    64'(bus.sb_write),    64'(pw.we));
          chk("commit_unit",        64'(bus.commit_unit), 64'(pw.unit));
          if (pw.we) begin
            chk("commit_rf_addr",    64'(bus.rf_addr),    64'(pw.rd));
            chk("commit_rf_data",    64'(bus.rf_data),    64'(pw.data));
            chk("commit_sb_address", 64'(bus.sb_address), 64'(pw.rd));
          end
        end else begin
          chk("idle_rf_we",    64'(bus.rf_we),    64'd0);
          chk("idle_sb_write", 64'(bus.sb_write), 64'd0);
        end
        fire = bus.unit_valid & bus.unit_ready;
        pend = 1'b0;
        if (fire != '0) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: grant=0x%0h, expected no transfer", fire);
          end else begin
            pw = expq.pop_front();
            chk("grant_onehot", 64'(fire), 64'(N'(1) << pw.unit));
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.unit_valid = '0;
    bus.unit_rd    = '0;
    bus.unit_data  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_ready", 64'(bus.unit_ready), 64'd0);
    rst_n = 1'b1;

    // Fairness: all four units valid twice over, rd 1..4
    for (int r = 0; r < 2; r++) begin
      for (int u = 0; u < N; u++) begin
        unit_push(u, AW'(u + 1), 32'hF000_0000 + 32'(r * 16 + u));
        exp_push(u, 1'b1, AW'(u + 1), 32'hF000_0000 + 32'(r * 16 + u));
      end
    end
    load_idle();
    drain(20);

    // Single request from unit 2, pointer at 0
    unit_push(2, 5'd5, 32'hDEAD_BEEF);
    exp_push(2, 1'b1, 5'd5, 32'hDEAD_BEEF);
    load_idle();
    #1 chk("single_ready", 64'(bus.unit_ready), 64'b0100);
    drain(10);

    // x0 destination from unit 1, pointer at 3
    unit_push(1, 5'd0, 32'h0000_1234);
    exp_push(1, 1'b0, 5'd0, 32'h0000_1234);
    load_idle();
    #1 chk("x0_ready", 64'(bus.unit_ready), 64'b0010);
    drain(10);

    // Unit 0 alone (pointer 2) moves the pointer to 1
    unit_push(0, 5'd7, 32'h0000_0007);
    exp_push(0, 1'b1, 5'd7, 32'h0000_0007);
    load_idle();
    drain(10);

    // Back-pressure: units 0 and 3, pointer 1 -> 3 then 0
    unit_push(0, 5'd10, 32'h0000_00A0);
    unit_push(3, 5'd11, 32'h0000_0B0B);
    exp_push(3, 1'b1, 5'd11, 32'h0000_0B0B);
    exp_push(0, 1'b1, 5'd10, 32'h0000_00A0);
    load_idle();
    #1 chk("bp_ready", 64'(bus.unit_ready), 64'b1000);
    drain(10);

    // Same rd from units 1 and 2, pointer 1 -> 1 then 2, last write wins
    unit_push(1, 5'd9, 32'h0000_0111);
    unit_push(2, 5'd9, 32'h0000_0222);
    exp_push(1, 1'b1, 5'd9, 32'h0000_0111);
    exp_push(2, 1'b1, 5'd9, 32'h0000_0222);
    load_idle();
    drain(10);
    chk("same_rd_last_wins", 64'(bus.rf_data), 64'h0000_0222);

    // Reset right after a transfer (pointer 3 -> unit 1 wins, pointer becomes 2)
    unit_push(1, 5'd12, 32'h00C0_FFEE);
    exp_push(1, 1'b1, 5'd12, 32'h00C0_FFEE);
    load_idle();
    step();
    chk("pre_reset_rf_we", 64'(bus.rf_we), 64'd1);
    rst_n          = 1'b0;
    bus.unit_valid = '0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset");

    // Pointer must be back at 0: units 0 and 3 -> 0 first
    unit_push(0, 5'd13, 32'h0000_0D0D);
    unit_push(3, 5'd14, 32'h0000_0E0E);
    exp_push(0, 1'b1, 5'd13, 32'h0000_0D0D);
    exp_push(3, 1'b1, 5'd14, 32'h0000_0E0E);
    load_idle();
    #1 chk("post_reset_ready", 64'(bus.unit_ready), 64'b0001);
    drain(10);

`ifdef COMMIT_ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stat_reset_conflicts", 64'(bus.stat_conflicts), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) unit_push(0, 5'd20, 32'h5000_0000 + 32'(k));
    for (int k = 0; k < 5; k++) unit_push(1, 5'd21, 32'h5100_0000 + 32'(k));
    for (int k = 0; k < 5; k++) begin
      exp_push(0, 1'b1, 5'd20, 32'h5000_0000 + 32'(k));
      exp_push(1, 1'b1, 5'd21, 32'h5100_0000 + 32'(k));
    end
    exp_push(0, 1'b1, 5'd20, 32'h5000_0005);
    load_idle();
    repeat (10) step();
    chk("stat_commits0",  64'(bus.stat_commits[31:0]),  64'd5);
    chk("stat_commits1",  64'(bus.stat_commits[63:32]), 64'd5);
    chk("stat_conflicts", 64'(bus.stat_conflicts),      64'd10);
    drain(10);
`endif

    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
